// File: rtl/crossbar_col_egress_queue_pkg.sv
// Shared constants for the crossbar column egress queues: queue-select field layout
// and the flat queue index used by the ingress demux and the full-flag vector.
package crossbar_col_egress_queue_pkg;

  localparam int DISPATCH_WIDTH = 32;
  localparam int PRI_NUM        = 8;
  localparam int PORT_NUM_COL   = 4;
  localparam int QUEUE_DEPTH    = 16;
  localparam int DROP_CNT_W     = 16;

  // Queue-select field positions, shared with the crossbar.
  localparam int SEL_W    = 5;
  localparam int PRI_MSB  = 4;
  localparam int PRI_LSB  = 2;
  localparam int PORT_MSB = 1;
  localparam int PORT_LSB = 0;

  localparam int PRI_W  = PRI_MSB - PRI_LSB + 1;
  localparam int PORT_W = PORT_MSB - PORT_LSB + 1;
  localparam int QIDX_W = PRI_W + PORT_W;

  typedef logic [PRI_W-1:0]  pri_t;
  typedef logic [PORT_W-1:0] port_t;
  typedef logic [QIDX_W-1:0] qidx_t;

  function automatic qidx_t queue_idx(input port_t port, input pri_t pri);
    return qidx_t'(port) * qidx_t'(PRI_NUM) + qidx_t'(pri);
  endfunction

endpackage

// File: rtl/crossbar_col_egress_queue_fwft_queue.sv
// First-word-fall-through queue: head word is readable combinationally whenever
// the queue holds data. Pushes while full and pops while empty are ignored.
module egress_fwft_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/crossbar_col_egress_queue.sv
// Column-side egress: demuxes crossbar column words into per-port priority queues
// and drains each port by strict priority through a valid/ready output register.
module crossbar_col_egress_queue #(
  parameter int DISPATCH_WIDTH = crossbar_col_egress_queue_pkg::DISPATCH_WIDTH,
  parameter int PRI_NUM        = crossbar_col_egress_queue_pkg::PRI_NUM,
  parameter int PORT_NUM_COL   = crossbar_col_egress_queue_pkg::PORT_NUM_COL,
  parameter int QUEUE_DEPTH    = crossbar_col_egress_queue_pkg::QUEUE_DEPTH,
  parameter int DROP_CNT_W     = crossbar_col_egress_queue_pkg::DROP_CNT_W
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_dat_valid,
  input  logic [4:0]                          i_queue_sel,
  input  logic [DISPATCH_WIDTH-1:0]           i_din,
  output logic [PORT_NUM_COL-1:0]             o_port_valid,
  input  logic [PORT_NUM_COL-1:0]             i_port_ready,
  output logic [PORT_NUM_COL*DISPATCH_WIDTH-1:0] o_port_dout,
  output logic [PORT_NUM_COL*3-1:0]           o_port_pri,
  output logic [PORT_NUM_COL*PRI_NUM-1:0]     o_queue_full,
  output logic [DROP_CNT_W-1:0]               o_drop_cnt
);

  import crossbar_col_egress_queue_pkg::*;

  localparam int QN = PORT_NUM_COL * PRI_NUM;

  pri_t                      sel_pri;
  port_t                     sel_port;
  qidx_t                     sel_q;
  logic                      drop;
  logic [QN-1:0]             q_push;
  logic [QN-1:0]             q_pop;
  logic [QN-1:0]             q_empty;
  logic [QN-1:0]             q_full;
  logic [DISPATCH_WIDTH-1:0] q_head [QN];
  logic [DROP_CNT_W-1:0]     drop_cnt_reg;

  assign sel_pri  = i_queue_sel[PRI_MSB:PRI_LSB];
  assign sel_port = i_queue_sel[PORT_MSB:PORT_LSB];
  assign sel_q    = queue_idx(sel_port, sel_pri);

  // Full is the pre-edge flag, so a same-cycle pop never rescues an arriving word.
  assign drop = i_dat_valid & q_full[sel_q];

  for (genvar gi = 0; gi < QN; gi++) begin : g_queue
    assign q_push[gi] = i_dat_valid & (sel_q == qidx_t'(gi));

    egress_fwft_queue #(
      .W     (DISPATCH_WIDTH),
      .DEPTH (QUEUE_DEPTH)
    ) u_queue (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (q_push[gi]),
      .din   (i_din),
      .pop   (q_pop[gi]),
      .dout  (q_head[gi]),
      .empty (q_empty[gi]),
      .full  (q_full[gi])
    );
  end

  for (genvar gi = 0; gi < PORT_NUM_COL; gi++) begin : g_port
    logic                      any_word;
    pri_t                      best_pri;
    logic                      load_en;
    logic                      valid_reg;
    logic [DISPATCH_WIDTH-1:0] dout_reg;
    pri_t                      pri_reg;

    // Ascending scan: the last non-empty queue seen is the highest priority.
    always_comb begin
      any_word = 1'b0;
      best_pri = '0;
      for (int k = 0; k < PRI_NUM; k++) begin
        if (!q_empty[gi*PRI_NUM + k]) begin
          any_word = 1'b1;
          best_pri = pri_t'(k);
        end
      end
    end

    assign load_en = ~valid_reg | i_port_ready[gi];

    for (genvar gk = 0; gk < PRI_NUM; gk++) begin : g_pop
      assign q_pop[gi*PRI_NUM + gk] = load_en & any_word & (best_pri == pri_t'(gk));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_reg <= 1'b0;
        dout_reg  <= '0;
        pri_reg   <= '0;
      end else if (load_en) begin
        valid_reg <= any_word;
        if (any_word) begin
          dout_reg <= q_head[gi*PRI_NUM + int'(best_pri)];
          pri_reg  <= best_pri;
        end
      end
    end

    assign o_port_valid[gi]                                = valid_reg;
    assign o_port_dout[gi*DISPATCH_WIDTH +: DISPATCH_WIDTH] = dout_reg;
    assign o_port_pri[gi*3 +: 3]                           = pri_reg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != '1)) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign o_queue_full = q_full;
  assign o_drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_crossbar_col_egress_queue.sv
// Bench for crossbar_col_egress_queue: directed scenarios plus random traffic,
// all checked against a queue-level reference model updated at each clock edge.
module tb_crossbar_col_egress_queue;

  localparam int W  = 32;
  localparam int PN = 8;
  localparam int PC = 4;
  localparam int QD = 16;
  localparam int DW = 16;
  localparam int QN = PC * PN;

  logic             i_clk       = 1'b0;
  logic             i_rst_n     = 1'b1;
  logic             i_dat_valid = 1'b0;
  logic [4:0]       i_queue_sel = '0;
  logic [W-1:0]     i_din       = '0;
  logic [PC-1:0]    i_port_ready = '0;
  logic [PC-1:0]    o_port_valid;
  logic [PC*W-1:0]  o_port_dout;
  logic [PC*3-1:0]  o_port_pri;
  logic [QN-1:0]    o_queue_full;
  logic [DW-1:0]    o_drop_cnt;

  crossbar_col_egress_queue dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_dat_valid  (i_dat_valid),
    .i_queue_sel  (i_queue_sel),
    .i_din        (i_din),
    .o_port_valid (o_port_valid),
    .i_port_ready (i_port_ready),
    .o_port_dout  (o_port_dout),
    .o_port_pri   (o_port_pri),
    .o_queue_full (o_queue_full),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one SV queue per (port, priority), plus output registers.
  logic [W-1:0]    mq [QN][$];
  logic [PC-1:0]   m_valid;
  logic [PC*W-1:0] m_dout;
  logic [PC*3-1:0] m_pri;
  int              m_drop;
  bit              auto_chk = 1'b1;

  function automatic void model_reset();
    for (int q = 0; q < QN; q++) mq[q].delete();
    m_valid = '0;
    m_dout  = '0;
    m_pri   = '0;
    m_drop  = 0;
  endfunction

  function automatic void model_edge();
    int sz [QN];
    int q;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < QN; i++) sz[i] = mq[i].size();
    for (int p = 0; p < PC; p++) begin
      if (m_valid[p] && i_port_ready[p])
        $display("port %0d egress pri=%0d data=%08h", p, m_pri[p*3 +: 3], m_dout[p*W +: W]);
      if (!m_valid[p] || i_port_ready[p]) begin
        m_valid[p] = 1'b0;
        for (int k = PN - 1; k >= 0; k--) begin
          if (!m_valid[p] && sz[p*PN + k] > 0) begin
            m_valid[p]         = 1'b1;
            m_dout[p*W +: W]   = mq[p*PN + k].pop_front();
            m_pri[p*3 +: 3]    = 3'(k);
          end
        end
      end
    end
    if (i_dat_valid) begin
      q = int'(i_queue_sel[1:0]) * PN + int'(i_queue_sel[4:2]);
      if (sz[q] < QD) mq[q].push_back(i_din);
      else if (m_drop < 65535) m_drop++;
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [QN-1:0] fexp;
    for (int q = 0; q < QN; q++) fexp[q] = (mq[q].size() == QD);
    chk({tag, "/valid"}, o_port_valid, m_valid);
    chk({tag, "/dout"},  o_port_dout,  m_dout);
    chk({tag, "/pri"},   o_port_pri,   m_pri);
    chk({tag, "/full"},  o_queue_full, fexp);
    chk({tag, "/drop"},  o_drop_cnt,   m_drop);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    if (auto_chk) compare_all("cyc");
  endtask

  task automatic push(input logic [4:0] sel, input logic [W-1:0] data);
    i_dat_valid = 1'b1;
    i_queue_sel = sel;
    i_din       = data;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "/valid"}, o_port_valid, 0);
    chk({tag, "/dout"},  o_port_dout,  0);
    chk({tag, "/pri"},   o_port_pri,   0);
    chk({tag, "/full"},  o_queue_full, 0);
    chk({tag, "/drop"},  o_drop_cnt,   0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int thr;
    model_reset();

    // Power-up reset
    #1 i_rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge i_clk);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    // Single word: pri 5, port 2, two-cycle latency
    i_port_ready = 4'b0100;
    push(5'b101_10, 32'hA5A5_0001);
    i_dat_valid = 1'b0;
    chk("t1_valid_e1", o_port_valid, 4'b0000);
    tick();
    chk("t1_valid_e2", o_port_valid, 4'b0100);
    chk("t1_dout", o_port_dout[2*W +: W], 32'hA5A5_0001);
    chk("t1_pri", o_port_pri[8:6], 3'd5);
    tick();
    chk("t1_drained", o_port_valid, 4'b0000);

    // Strict priority with the first word already latched
    i_port_ready = 4'b0000;
    push(5'b001_00, 32'h11);
    push(5'b110_00, 32'h66);
    push(5'b011_00, 32'h33);
    i_dat_valid = 1'b0;
    chk("t2_hold_valid", o_port_valid[0], 1'b1);
    chk("t2_hold_dout", o_port_dout[W-1:0], 32'h11);
    i_port_ready = 4'b0001;
    tick();
    chk("t2_second", o_port_dout[W-1:0], 32'h66);
    chk("t2_second_pri", o_port_pri[2:0], 3'd6);
    tick();
    chk("t2_third", o_port_dout[W-1:0], 32'h33);
    chk("t2_third_pri", o_port_pri[2:0], 3'd3);
    tick();
    chk("t2_done", o_port_valid[0], 1'b0);

    // Full and drop on port 1 pri 0
    i_port_ready = 4'b0000;
    for (int i = 0; i < 18; i++) push(5'b000_01, 32'(i));
    i_dat_valid = 1'b0;
    chk("t3_full8", o_queue_full[8], 1'b1);
    chk("t3_drop", o_drop_cnt, 16'd1);
    chk("t3_outreg", o_port_dout[W +: W], 32'd0);
    i_port_ready = 4'b0010;
    for (int i = 0; i < 17; i++) begin
      chk("t3_seq_valid", o_port_valid[1], 1'b1);
      chk("t3_seq", o_port_dout[W +: W], 32'(i));
      tick();
    end
    chk("t3_no17", o_port_valid[1], 1'b0);

    // Backpressure hold on port 3 with a late higher-priority arrival
    i_port_ready = 4'b0000;
    push(5'b010_11, 32'hBEEF_0004);
    i_dat_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) push(5'b111_11, 32'h77);
      else tick();
      i_dat_valid = 1'b0;
      chk("t4_hold_valid", o_port_valid[3], 1'b1);
      chk("t4_hold_dout", o_port_dout[3*W +: W], 32'hBEEF_0004);
      chk("t4_hold_pri", o_port_pri[11:9], 3'd2);
    end
    i_port_ready = 4'b1000;
    tick();
    chk("t4_next_dout", o_port_dout[3*W +: W], 32'h77);
    chk("t4_next_pri", o_port_pri[11:9], 3'd7);
    tick();

    // Drop counter saturation
    auto_chk     = 1'b0;
    i_port_ready = 4'b0000;
    i_dat_valid  = 1'b1;
    i_queue_sel  = 5'b000_01;
    for (int i = 0; i < 65560; i++) begin
      i_din = 32'(i);
      tick();
    end
    i_dat_valid = 1'b0;
    auto_chk    = 1'b1;
    chk("t5_sat", o_drop_cnt, 16'hFFFF);
    compare_all("t5");
    i_port_ready = 4'b1111;
    repeat (20) tick();

    // Reset with words queued
    i_port_ready = 4'b0000;
    for (int i = 0; i < 10; i++) push(5'($urandom), $urandom);
    i_dat_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    model_reset();
    @(negedge i_clk);
    tick();
    i_rst_n = 1'b1;
    i_port_ready = 4'b1111;
    tick();
    chk("t6_no_stale", o_port_valid, 4'b0000);
    push(5'b000_00, 32'hC0DE_0001);
    i_dat_valid = 1'b0;
    chk("t6_lat_e1", o_port_valid, 4'b0000);
    tick();
    chk("t6_lat_e2", o_port_valid, 4'b0001);
    chk("t6_dout", o_port_dout[W-1:0], 32'hC0DE_0001);
    tick();

    // Random traffic: low drain rate first to build backlog, then high
    for (int c = 0; c < 3000; c++) begin
      thr          = (c < 1500) ? 30 : 80;
      i_dat_valid  = ($urandom_range(0, 9) < 7);
      i_queue_sel  = 5'($urandom);
      i_din        = $urandom;
      for (int p = 0; p < PC; p++) i_port_ready[p] = ($urandom_range(0, 99) < thr);
      tick();
    end
    i_dat_valid  = 1'b0;
    i_port_ready = 4'b1111;
    repeat (80) tick();
    chk("final_idle", o_port_valid, 4'b0000);
    chk("final_empty", o_queue_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crossbar_col_egress_queue.md
Name: crossbar_col_egress_queue

Overview:
- Column-side receiver for one crossbar column output (queue_sel, dout, dat_valid).
- Demultiplexes each word into one of 4 destination ports × 8 priority queues (32 FWFT queues).
- Each port drains its queues to egress by strict priority behind a valid/ready output register.
- One instance per crossbar column; the top level instantiates four.

Parameters:
- DISPATCH_WIDTH, 32, word width; must match the crossbar column dout.
- PRI_NUM, 8, priority levels per port; 7 is the highest.
- PORT_NUM_COL, 4, destination ports served by the column.
- QUEUE_DEPTH, 16, words per queue; power of 2, ≥2.
- DROP_CNT_W, 16, drop counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_dat_valid  in  1  column word valid; no backpressure toward the crossbar
- i_queue_sel  in  5  [4:2] priority, [1:0] destination port within column
- i_din  in  DISPATCH_WIDTH  column word
- o_port_valid  out  PORT_NUM_COL  per-port egress valid
- i_port_ready  in  PORT_NUM_COL  per-port egress ready
- o_port_dout  out  PORT_NUM_COL*DISPATCH_WIDTH  port p occupies bits [p*W +: W]
- o_port_pri  out  PORT_NUM_COL*3  priority of the word held in the port p output register
- o_queue_full  out  PORT_NUM_COL*PRI_NUM  full flag per queue; index = port*8 + pri
- o_drop_cnt  out  DROP_CNT_W  saturating count of dropped words

Behaviour:
- Reset (async assert, sync release):
  - All queues empty.
  - o_port_valid = 0, o_port_dout = 0, o_port_pri = 0.
  - o_queue_full = 0, o_drop_cnt = 0.
  - Reset mid-operation discards all stored and in-flight words. No partial state survives.
- Ingress, every cycle with i_dat_valid = 1:
  - Target queue q = i_queue_sel[1:0]*8 + i_queue_sel[4:2].
  - If full[q] (registered, pre-edge value) = 0: push i_din.
  - Else: drop the word and increment o_drop_cnt, saturating at all ones.
  - A pop from the same queue in the same cycle does NOT rescue a word arriving on a full queue; it is still dropped.
- Queue (FWFT):
  - Registered count, 0..QUEUE_DEPTH; full when count == QUEUE_DEPTH.
  - Head word is visible combinationally when non-empty.
  - Simultaneous push+pop on a non-full, non-empty queue leaves count unchanged and preserves order.
  - Read and write pointers wrap modulo QUEUE_DEPTH.
- Egress, per port p, each cycle:
  - load_en = ~o_port_valid[p] | i_port_ready[p].
  - If load_en and any of the 8 queues of port p is non-empty: pop the highest non-empty priority and register its head into o_port_dout / o_port_pri. o_port_valid[p] = 1 next cycle.
  - If load_en and all queues are empty: o_port_valid[p] = 0 next cycle; dout and pri hold.
  - If o_port_valid[p] = 1 and i_port_ready[p] = 0: dout, pri and valid hold stable (AXI-style; no change while stalled).
  - Back-to-back: ready held high with backlog gives one word per cycle per port.
- Latency:
  - Word pushed at edge E, with port idle and no higher-priority backlog, is popped during the cycle after E.
  - o_port_valid rises at edge E+1, i.e. 2 cycles from i_dat_valid to o_port_valid.
- Strict priority:
  - A higher priority arriving while a lower one sits in the output register does not preempt it.
  - The higher priority is taken at the next load.
  - Starvation of low priorities under sustained high-priority load is intended.
- Ports are fully independent; all 4 may load in the same cycle while ingress pushes to any queue.
- i_queue_sel is ignored when i_dat_valid = 0.

Decomposition:
- Shared package/defines:
  - DISPATCH_WIDTH and PRI_NUM.
  - Queue-select field positions (PRI_MSB=4, PRI_LSB=2, PORT_MSB=1, PORT_LSB=0), shared with the crossbar.
  - Queue-index function port*PRI_NUM+pri.
- Sub-module egress_fwft_queue (W, DEPTH):
  - Ports: clk, async rst_n, push, din, pop, dout, empty, full.
  - Instantiated 32× in a generate loop.
- Per-port priority encoder and output register live in the top module.

Test Plan:
- Single word: i_queue_sel=5'b101_10 (pri 5, port 2), din=0xA5A5_0001, port 2 ready=1 → o_port_valid[2]=1 exactly 2 cycles later, dout=0xA5A5_0001, pri=5; other ports stay valid=0.
- Priority order, port 0 ready=0: push pri 1 (0x11), pri 6 (0x66), pri 3 (0x33) → output register holds 0x11, loaded before the others arrived. Then ready=1 → sequence 0x11, 0x66, 0x33, one per cycle.
- Full and drop: port 1 pri 0, ready=0, 18 pushes of 0..17 → 1 word in the output register, queue full after 17 pushes, o_queue_full[8]=1, o_drop_cnt=1. Release ready → words 0..16 out in order, value 17 never appears.
- Backpressure hold: valid=1 with ready=0 for 5 cycles → dout and pri bit-stable; a new higher-priority push does not change them.
- Saturation: force 65540 drops → o_drop_cnt=0xFFFF.
- Reset mid-stream: assert i_rst_n=0 with 10 words queued → all outputs 0 asynchronously. After release, no stale word ever emerges and new pushes behave as after power-up.
